// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg
// Shared types and default widths for the multi-channel pulse generator.
//   chan_state_t : per-channel FSM state (IDLE / HIGH / LOW)
//   pulse_mode_t : channel operating mode (CONTINUOUS / BURST)
package pulse_gen_pkg;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_BURST_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } chan_state_t;

  typedef enum logic {
    CONTINUOUS = 1'b0,
    BURST      = 1'b1
  } pulse_mode_t;

endpackage : pulse_gen_pkg

// File: rtl/pulse_gen_channel.sv
// pulse_gen_channel
// One independent pulse channel: IDLE/HIGH/LOW FSM with a phase down-counter
// and a burst pulse counter. All outputs are registered.
// Ports:
//   clk_i         : clock, rising edge
//   rst_i         : synchronous active-high reset
//   enable_i      : run enable; dropping it aborts to IDLE without done
//   mode_i        : 0 = continuous, 1 = burst (latched at start)
//   start_i       : burst trigger strobe (only honoured in IDLE)
//   high_cycles_i : high phase length in cycles (0 = channel off)
//   low_cycles_i  : low phase length in cycles (0 = LOW skipped)
//   burst_len_i   : pulses per burst (latched at start)
//   pulse_o       : pulse train
//   busy_o        : channel in HIGH or LOW
//   done_o        : one-cycle burst completion strobe
module pulse_gen_channel
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               mode_i,
  input  logic               start_i,
  input  logic [CNT_W-1:0]   high_cycles_i,
  input  logic [CNT_W-1:0]   low_cycles_i,
  input  logic [BURST_W-1:0] burst_len_i,
  output logic               pulse_o,
  output logic               busy_o,
  output logic               done_o
);

  chan_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;     // cycles left in current phase, minus one
  logic [CNT_W-1:0]   low_q, low_d;     // low length latched at each HIGH entry
  logic [BURST_W-1:0] rem_q, rem_d;     // burst pulses not yet finished
  pulse_mode_t        mode_q, mode_d;

  logic pulse_q, pulse_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Set when a new HIGH phase should begin from the live inputs; the high
  // length lives only in the counter, so it needs no separate register.
  logic launch;
  logic burst_end;

  // State register and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      low_q   <= '0;
      rem_q   <= '0;
      mode_q  <= CONTINUOUS;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      low_q   <= low_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    low_d     = low_q;
    rem_d     = rem_q;
    mode_d    = mode_q;
    launch    = 1'b0;
    burst_end = 1'b0;

    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pulse_mode_t'(mode_i) == CONTINUOUS) begin
            launch = 1'b1;
            mode_d = CONTINUOUS;
          end else if (start_i) begin
            if (burst_len_i == '0) begin
              // Empty burst: immediate completion, never leaves IDLE
              burst_end = 1'b1;
            end else begin
              launch = 1'b1;
              mode_d = BURST;
              rem_d  = burst_len_i;
            end
          end
        end

        HIGH: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            if (mode_q == BURST) rem_d = rem_q - 1'b1;
            if (low_q != '0) begin
              state_d = LOW;
              cnt_d   = low_q - 1'b1;
            end else if (mode_q == BURST && rem_q == BURST_W'(1)) begin
              // No LOW phase, so completion happens leaving the last HIGH
              state_d   = IDLE;
              burst_end = 1'b1;
            end else begin
              launch = 1'b1;
            end
          end
        end

        LOW: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (mode_q == BURST && rem_q == '0) begin
            state_d   = IDLE;
            burst_end = 1'b1;
          end else begin
            launch = 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    // Latch the phase lengths; a zero high length parks the channel in IDLE
    if (launch) begin
      low_d = low_cycles_i;
      if (high_cycles_i != '0) begin
        state_d = HIGH;
        cnt_d   = high_cycles_i - 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Output decode from the next state so the registered outputs align with it
  always_comb begin
    pulse_d = (state_d == HIGH);
    busy_d  = (state_d != IDLE);
    done_d  = burst_end;
  end

  assign pulse_o = pulse_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule : pulse_gen_channel

// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi
// NUM_CH fully independent programmable pulse channels.
// Ports:
//   clk         : clock, rising edge
//   reset       : synchronous active-high reset of all channels
//   enable      : per-channel run enable
//   mode        : per-channel mode, 0 = continuous, 1 = burst
//   start       : per-channel burst trigger strobe
//   high_cycles : NUM_CH x CNT_W high durations, channel 0 in the LSBs
//   low_cycles  : NUM_CH x CNT_W low durations
//   burst_len   : NUM_CH x BURST_W pulses per burst
//   pulse_out   : per-channel registered pulse train
//   busy        : per-channel not-IDLE flag
//   done        : per-channel burst completion strobe
module pulse_gen_multi
  import pulse_gen_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         enable,
  input  logic [NUM_CH-1:0]         mode,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH*CNT_W-1:0]   high_cycles,
  input  logic [NUM_CH*CNT_W-1:0]   low_cycles,
  input  logic [NUM_CH*BURST_W-1:0] burst_len,
  output logic [NUM_CH-1:0]         pulse_out,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         done
);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      pulse_gen_channel #(
        .CNT_W   (CNT_W),
        .BURST_W (BURST_W)
      ) u_ch (
        .clk_i         (clk),
        .rst_i         (reset),
        .enable_i      (enable[gi]),
        .mode_i        (mode[gi]),
        .start_i       (start[gi]),
        .high_cycles_i (high_cycles[gi*CNT_W +: CNT_W]),
        .low_cycles_i  (low_cycles[gi*CNT_W +: CNT_W]),
        .burst_len_i   (burst_len[gi*BURST_W +: BURST_W]),
        .pulse_o       (pulse_out[gi]),
        .busy_o        (busy[gi]),
        .done_o        (done[gi])
      );
    end
  endgenerate

endmodule : pulse_gen_multi

// File: tb/tb_pulse_gen_multi.sv
module tb_pulse_gen_multi;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 16;
  localparam int BURST_W = 8;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_CH-1:0]         enable, mode, start;
  logic [NUM_CH*CNT_W-1:0]   high_cycles, low_cycles;
  logic [NUM_CH*BURST_W-1:0] burst_len;
  logic [NUM_CH-1:0]         pulse_out, busy, done;

  pulse_gen_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .start(start),
    .high_cycles(high_cycles), .low_cycles(low_cycles), .burst_len(burst_len),
    .pulse_out(pulse_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: position within the current period plus pulses left.
  bit m_act  [NUM_CH];
  bit m_done [NUM_CH];
  bit m_mode [NUM_CH];
  int m_t    [NUM_CH];
  int m_hi   [NUM_CH];
  int m_lo   [NUM_CH];
  int m_rem  [NUM_CH];

  function automatic int hi_in(int c);
    return int'(high_cycles[c*CNT_W +: CNT_W]);
  endfunction
  function automatic int lo_in(int c);
    return int'(low_cycles[c*CNT_W +: CNT_W]);
  endfunction
  function automatic int bl_in(int c);
    return int'(burst_len[c*BURST_W +: BURST_W]);
  endfunction

  task automatic chk(string tag, int c, int obs, int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s ch%0d: observed %0d expected %0d", tag, c, obs, exp);
    end
  endtask

  task automatic begin_run(int c, bit m, int rem);
    m_act[c]  = 1'b1;
    m_mode[c] = m;
    m_rem[c]  = rem;
    m_t[c]    = 0;
    m_hi[c]   = hi_in(c);
    m_lo[c]   = lo_in(c);
    if (m_hi[c] == 0) m_act[c] = 1'b0;
  endtask

  task automatic model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      m_done[c] = 1'b0;
      if (reset || !enable[c]) begin
        m_act[c] = 1'b0;
      end else if (!m_act[c]) begin
        if (!mode[c]) begin
          begin_run(c, 1'b0, 0);
        end else if (start[c]) begin
          if (bl_in(c) == 0) m_done[c] = 1'b1;
          else begin_run(c, 1'b1, bl_in(c));
        end
      end else begin
        m_t[c]++;
        if (m_t[c] == m_hi[c] + m_lo[c]) begin
          if (m_mode[c]) begin
            m_rem[c]--;
            if (m_rem[c] == 0) begin
              m_act[c]  = 1'b0;
              m_done[c] = 1'b1;
            end
          end
          if (m_act[c]) begin
            m_t[c]  = 0;
            m_hi[c] = hi_in(c);
            m_lo[c] = lo_in(c);
            if (m_hi[c] == 0) m_act[c] = 1'b0;
          end
        end
      end
    end
  endtask

  // One clock: update model at the edge, compare just after, clear strobes.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      chk("pulse", c, int'(pulse_out[c]), int'(m_act[c] && (m_t[c] < m_hi[c])));
      chk("busy",  c, int'(busy[c]),      int'(m_act[c]));
      chk("done",  c, int'(done[c]),      int'(m_done[c]));
    end
    start = '0;
  endtask

  task automatic cfg(int c, bit m, int hi, int lo, int bl);
    mode[c] = m;
    high_cycles[c*CNT_W +: CNT_W]   = CNT_W'(hi);
    low_cycles[c*CNT_W +: CNT_W]    = CNT_W'(lo);
    burst_len[c*BURST_W +: BURST_W] = BURST_W'(bl);
  endtask

  initial begin
    int cyc;
    int npulse;
    bit prev;
    bit seen_done;
    logic [4:0] pat;

    for (int c = 0; c < NUM_CH; c++) begin
      m_act[c] = 0; m_done[c] = 0; m_mode[c] = 0;
      m_t[c] = 0; m_hi[c] = 0; m_lo[c] = 0; m_rem[c] = 0;
    end
    reset = 1'b1; enable = '0; mode = '0; start = '0;
    high_cycles = '0; low_cycles = '0; burst_len = '0;
    repeat (3) step();
    chk("reset_outputs", 0, int'({pulse_out, busy, done}), 0);
    #1 reset = 1'b0;
    repeat (9) step();

    // Continuous 3/2: pattern 11100 from the first cycle after enable
    cfg(0, 1'b0, 3, 2, 0);
    enable[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      pat[4-i] = pulse_out[0];
    end
    chk("cont_pattern", 0, int'(pat), 28);
    repeat (20) step();
    enable[0] = 1'b0;
    step();

    // Burst 4 x (2 high, 5 low): done 28 cycles after start
    cfg(1, 1'b1, 2, 5, 4);
    enable[1] = 1'b1;
    step();
    start[1] = 1'b1;
    prev = 1'b0; npulse = 0; cyc = 0; seen_done = 1'b0;
    step();
    if (pulse_out[1]) npulse++;
    prev = pulse_out[1];
    while (cyc < 60 && !seen_done) begin
      step();
      cyc++;
      if (pulse_out[1] && !prev) npulse++;
      prev = pulse_out[1];
      if (done[1]) begin
        seen_done = 1'b1;
        chk("busy_fall_at_done", 1, int'(busy[1]), 0);
      end
    end
    chk("burst_done_latency", 1, cyc, 28);
    chk("burst_pulse_count", 1, npulse, 4);
    step();
    chk("done_one_cycle", 1, int'(done[1]), 0);

    // Reset at the 50th cycle of a 100-cycle high phase
    cfg(0, 1'b0, 100, 3, 0);
    enable[0] = 1'b1;
    repeat (50) step();
    reset = 1'b1;
    step();
    chk("reset_mid_high", 0, int'({pulse_out, busy, done}), 0);
    reset = 1'b0;
    step();
    chk("restart_after_reset", 0, int'(pulse_out[0]), 1);
    repeat (110) step();
    enable[0] = 1'b0;
    step();

    // high_cycles = 0 is the off setting
    cfg(2, 1'b0, 0, 4, 0);
    enable[2] = 1'b1;
    repeat (10) begin
      step();
      chk("high0_off", 2, int'(pulse_out[2]), 0);
    end
    // low_cycles = 0 gives a constant high
    cfg(2, 1'b0, 4, 0, 0);
    step();
    repeat (12) begin
      step();
      chk("low0_const", 2, int'(pulse_out[2]), 1);
    end
    enable[2] = 1'b0;
    step();

    // Empty burst: done next cycle, never busy
    cfg(3, 1'b1, 3, 3, 0);
    enable[3] = 1'b1;
    start[3] = 1'b1;
    step();
    chk("bl0_done", 3, int'(done[3]), 1);
    chk("bl0_busy", 3, int'(busy[3]), 0);
    step();
    enable[3] = 1'b0;

    // Abort mid-burst, then a start while busy must not extend the burst
    cfg(1, 1'b1, 3, 3, 5);
    start[1] = 1'b1;
    repeat (10) step();
    enable[1] = 1'b0;
    step();
    chk("abort_pulse", 1, int'(pulse_out[1]), 0);
    chk("abort_done", 1, int'(done[1]), 0);
    enable[1] = 1'b1;
    start[1] = 1'b1;
    step();
    npulse = 1; prev = pulse_out[1]; cyc = 0; seen_done = 1'b0;
    while (cyc < 80 && !seen_done) begin
      if (cyc == 8) start[1] = 1'b1;
      step();
      cyc++;
      if (pulse_out[1] && !prev) npulse++;
      prev = pulse_out[1];
      seen_done = done[1];
    end
    chk("ignored_start_count", 1, npulse, 5);
    chk("ignored_start_done", 1, int'(seen_done), 1);
    enable = '0;
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(9) == 0)
          cfg(c, (i % 200 < 100) ? 1'b0 : 1'($urandom_range(1)),
              int'($urandom_range(4)), int'($urandom_range(4)), int'($urandom_range(3)));
        if ($urandom_range(19) == 0) enable[c] = ~enable[c];
        if ($urandom_range(5) == 0) start[c] = 1'b1;
      end
      if ($urandom_range(199) == 0) reset = 1'b1;
      step();
      reset = 1'b0;
    end
    enable = '0;
    step();

    // Four independent continuous channels for 1000 cycles
    cfg(0, 1'b0, 2, 2, 0);
    cfg(1, 1'b0, 1, 3, 0);
    cfg(2, 1'b0, 5, 1, 0);
    cfg(3, 1'b0, 0, 4, 0);
    enable = '1;
    for (int i = 0; i < 1000; i++) begin
      step();
      chk("ch3_off", 3, int'(pulse_out[3]), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_pulse_gen_multi
